exc_arbiter: RTL and testbench
==============================

# exc_arbiter

Exception arbiter and redirect controller for the 3-stage MIPS core; it sits directly upstream of the coprocessor-0 register file. It collects raw fault flags from fetch, execute and memory, and selects one exception per cycle by fixed priority. It tracks branch-delay-slot state and issues a registered, single-cycle commit record (code, EPC, BadVAddr, BD) to CP0. It also drives the pipeline flush and the PC redirect to the handler, or to EPC on ERET.

## Interface
Parameters:
- HANDLER_PC, 32'hBFC0_0380, exception vector loaded on redirect
- FLUSH_CYCLES, 2, cycles `flush` stays high after a redirect (range 1..7)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- ex_valid  in  1  execute stage holds a real (non-bubble) instruction
- pc_if  in  32  fetch PC
- pc_ex  in  32  PC of instruction in execute
- if_adel  in  1  fetch address misaligned
- ri  in  1  reserved instruction in execute
- ovf  in  1  arithmetic overflow in execute
- syscall  in  1  SYSCALL in execute
- brk  in  1  BREAK in execute
- mem_err  in  1  data address misaligned
- mem_store  in  1  faulting access is a store
- mem_addr  in  32  faulting data address
- is_branch_ex  in  1  execute instruction is a branch or jump
- eret  in  1  ERET in execute
- exl  in  1  CP0 Status.EXL
- epc_in  in  32  CP0 EPC
- exc_valid  out  1  one-cycle commit strobe to CP0
- exc_code  out  5  Cause.ExcCode
- exc_epc  out  32  value for EPC
- exc_badvaddr  out  32  value for BadVAddr
- exc_bd  out  1  Cause.BD
- eret_commit  out  1  one-cycle strobe: CP0 clears EXL
- redirect_valid  out  1  one-cycle strobe: load redirect_pc into PC
- redirect_pc  out  32  target PC
- flush  out  1  squash IF/EX contents

## Operation
- Priority, highest first: interrupt (EXC_INT_EN only) > if_adel (0x04) > ri (0x0a) > ovf (0x0c) > syscall (0x08) > brk (0x09) > mem_err (0x04 load / 0x05 store).
- Execute-stage sources count only when ex_valid=1. if_adel and mem_err are not qualified by ex_valid.
- bd_q: on each ex_valid cycle, bd_q <= is_branch_ex. bd_q=1 means the current execute instruction is in a delay slot.
- EPC selection:
  - if_adel: pc_if; badvaddr = pc_if.
  - Otherwise: pc_ex, or pc_ex-4 when bd_q=1; badvaddr = mem_addr for mem_err, else 0.
- exc_bd = bd_q for execute and memory sources, 0 for if_adel.
- ERET with no exception in the same cycle: redirect_pc = epc_in, eret_commit = 1, exc_valid = 0.
- ERET and an exception in the same cycle: the exception wins and ERET is dropped.
- Synchronous exceptions are taken regardless of exl. CP0 decides whether EPC is written.
- FSM:
  - RUN: on exception or ERET, go to FLUSH and load the counter with FLUSH_CYCLES-1.
  - FLUSH: all sources are ignored (they belong to squashed instructions); the counter decrements; at 0, return to RUN.
  - FLUSH_CYCLES=1: FLUSH lasts exactly one cycle, then RUN.

## Timing
- Sources sampled in cycle N. exc_valid, eret_commit, redirect_valid and all payload outputs are registered and valid in N+1 only.
- flush is high from N+1 through N+FLUSH_CYCLES.
- A source present in RUN at cycle N+FLUSH_CYCLES+1 is the first one eligible again.
- Reset values: every output 0, redirect_pc 0, state RUN, counter 0, bd_q 0, synchronizers 0.
- Reset mid-FLUSH aborts the flush immediately, with no residual strobe.
- Payload outputs hold their last values between strobes. They are only meaningful while a strobe is high.

## Configuration
- EXC_INT_EN:
  - Defined: adds ports `hw_int` in 6 and `int_mask` in 8 (Status.IM & {8{Status.IE}}).
  - hw_int passes through a 2-flop synchronizer. Interrupt is pending when (sync & int_mask[7:2]) != 0 and exl=0.
  - A pending interrupt is taken in RUN as code 0x00 with EPC/BD rules of the execute instruction. It requires ex_valid=1 and is held pending until then.
  - Undefined: no interrupt ports or logic; highest priority is if_adel.

## Structure
- Shared package cpu_pkg holds:
  - Exception-code constants EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV.
  - The FSM state typedef {RUN, FLUSH}.
  - Default HANDLER_PC.
- One sub-module, exc_prio_enc: combinational priority encoder taking the source vector and producing {hit, code, sel_if, sel_mem}.

## Test plan
- ovf=1, ex_valid=1, pc_ex=0x100, bd_q=0 -> next cycle exc_valid=1, code 0x0c, epc 0x100, bd 0, redirect_pc 0xBFC00380; flush high 2 cycles.
- Branch at 0x200 then syscall at 0x204 -> code 0x08, epc 0x200, bd 1.
- mem_err=1, mem_store=1, mem_addr=0x1003 -> code 0x05, badvaddr 0x1003; with ri=1 in the same cycle, code 0x0a wins instead.
- eret=1, epc_in=0x400 -> eret_commit=1, redirect_pc 0x400, exc_valid 0; eret together with brk -> code 0x09, eret_commit 0.
- brk raised during FLUSH -> no strobe. Reset asserted mid-FLUSH -> flush=0 next cycle, state RUN.
- EXC_INT_EN: hw_int[0]=1, int_mask=0x04, exl=0 -> strobe 3 cycles later (2 sync + register) with code 0x00. With exl=1 -> no strobe.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the exception path: CP0 exception codes,
// the arbiter FSM state type, the default exception vector and the
// bit layout of the exception source vector.
package cpu_pkg;

   // Cause.ExcCode values
   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_BP   = 5'h09;
   localparam logic [4:0] EXC_RI   = 5'h0a;
   localparam logic [4:0] EXC_OV   = 5'h0c;

   // Arbiter FSM states
   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } exc_state_t;

   // Boot-time exception vector
   localparam logic [31:0] DEFAULT_HANDLER_PC = 32'hBFC0_0380;

   // Bit positions in the source vector handed to the priority encoder,
   // highest priority in the most significant bit.
   localparam int SRC_INT  = 6;
   localparam int SRC_ADEL = 5;
   localparam int SRC_RI   = 4;
   localparam int SRC_OV   = 3;
   localparam int SRC_SYS  = 2;
   localparam int SRC_BP   = 1;
   localparam int SRC_MEM  = 0;
   localparam int SRC_W    = 7;

   // EPC of an execute-stage instruction: a delay-slot instruction
   // restarts from its branch, one word earlier.
   function automatic logic [31:0] bd_epc(input logic [31:0] pc, input logic bd);
      return bd ? (pc - 32'd4) : pc;
   endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority exception encoder. Picks the highest set bit of the
// source vector and reports the matching Cause.ExcCode together with
// which payload source (fetch PC or data address) the winner needs.
module exc_prio_enc
   import cpu_pkg::*;
(
   input  logic [SRC_W-1:0] src,
   input  logic             mem_store,
   output logic             hit,
   output logic [4:0]       code,
   output logic             sel_if,
   output logic             sel_mem
);

   // Priority chain, highest source first
   always_comb begin
      hit     = 1'b0;
      code    = EXC_INT;
      sel_if  = 1'b0;
      sel_mem = 1'b0;
      if (src[SRC_INT]) begin
         hit  = 1'b1;
         code = EXC_INT;
      end else if (src[SRC_ADEL]) begin
         hit    = 1'b1;
         code   = EXC_ADEL;
         sel_if = 1'b1;
      end else if (src[SRC_RI]) begin
         hit  = 1'b1;
         code = EXC_RI;
      end else if (src[SRC_OV]) begin
         hit  = 1'b1;
         code = EXC_OV;
      end else if (src[SRC_SYS]) begin
         hit  = 1'b1;
         code = EXC_SYS;
      end else if (src[SRC_BP]) begin
         hit  = 1'b1;
         code = EXC_BP;
      end else if (src[SRC_MEM]) begin
         hit     = 1'b1;
         code    = mem_store ? EXC_ADES : EXC_ADEL;
         sel_mem = 1'b1;
      end
   end

endmodule

// File: rtl/exc_arbiter.sv
// Exception arbiter and redirect controller for the 3-stage core.
// Collects fault flags from fetch, execute and memory, commits one
// exception per cycle to CP0 as a registered single-cycle record, and
// drives the pipeline flush plus the PC redirect (handler, or EPC on ERET).
// Optional feature macro: EXC_INT_EN adds hw_int/int_mask and a
// synchronized, maskable hardware interrupt as the top-priority source.
module exc_arbiter
   import cpu_pkg::*;
#(
   parameter logic [31:0] HANDLER_PC   = DEFAULT_HANDLER_PC,
   parameter int          FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic [31:0] pc_if,
   input  logic [31:0] pc_ex,
   input  logic        if_adel,
   input  logic        ri,
   input  logic        ovf,
   input  logic        syscall,
   input  logic        brk,
   input  logic        mem_err,
   input  logic        mem_store,
   input  logic [31:0] mem_addr,
   input  logic        is_branch_ex,
   input  logic        eret,
   input  logic        exl,
   input  logic [31:0] epc_in,
   output logic        exc_valid,
   output logic [4:0]  exc_code,
   output logic [31:0] exc_epc,
   output logic [31:0] exc_badvaddr,
   output logic        exc_bd,
   output logic        eret_commit,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        flush
`ifdef EXC_INT_EN
   ,
   input  logic [5:0]  hw_int,
   input  logic [7:0]  int_mask
`endif
);

   localparam logic [0:0] ST_RUN   = RUN;
   localparam logic [0:0] ST_FLUSH = FLUSH;
   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   logic [0:0]       state;
   logic [2:0]       flush_cnt;
   logic             bd_q;
   logic             run;
   logic             int_req;
   logic [SRC_W-1:0] src;
   logic             hit;
   logic [4:0]       code;
   logic             sel_if;
   logic             sel_mem;
   logic             eret_take;
   logic [31:0]      epc_sel;
   logic [31:0]      bva_sel;
   logic             bd_sel;

   assign run = (state == ST_RUN);

`ifdef EXC_INT_EN
   logic [5:0] int_sync1;
   logic [5:0] int_sync2;
   logic [1:0] unused_sw_mask;

   assign unused_sw_mask = int_mask[1:0];

   // Two-flop synchronizer for the asynchronous interrupt lines
   always_ff @(posedge clk) begin
      if (!reset) begin
         int_sync1 <= '0;
         int_sync2 <= '0;
      end else begin
         int_sync1 <= hw_int;
         int_sync2 <= int_sync1;
      end
   end

   // Interrupt is only taken against a real execute instruction, so it
   // stays pending through bubbles.
   assign int_req = ex_valid && (|(int_sync2 & int_mask[7:2])) && !exl;
`else
   logic unused_exl;

   assign unused_exl = exl;
   assign int_req    = 1'b0;
`endif

   // Sources are ignored while flushing: they belong to squashed instructions.
   assign src[SRC_INT]  = run & int_req;
   assign src[SRC_ADEL] = run & if_adel;
   assign src[SRC_RI]   = run & ex_valid & ri;
   assign src[SRC_OV]   = run & ex_valid & ovf;
   assign src[SRC_SYS]  = run & ex_valid & syscall;
   assign src[SRC_BP]   = run & ex_valid & brk;
   assign src[SRC_MEM]  = run & mem_err;

   exc_prio_enc u_prio (
      .src       (src),
      .mem_store (mem_store),
      .hit       (hit),
      .code      (code),
      .sel_if    (sel_if),
      .sel_mem   (sel_mem)
   );

   // A simultaneous exception wins over ERET.
   assign eret_take = run & ex_valid & eret & ~hit;

   // Payload selection for the winning exception
   always_comb begin
      epc_sel = bd_epc(pc_ex, bd_q);
      bva_sel = 32'd0;
      bd_sel  = bd_q;
      if (sel_if) begin
         epc_sel = pc_if;
         bva_sel = pc_if;
         bd_sel  = 1'b0;
      end else if (sel_mem) begin
         bva_sel = mem_addr;
      end
   end

   // Delay-slot tracking: remembers whether the previous real execute
   // instruction was a branch.
   always_ff @(posedge clk) begin
      if (!reset) begin
         bd_q <= 1'b0;
      end else if (ex_valid) begin
         bd_q <= is_branch_ex;
      end
   end

   // Registered commit record, strobes and redirect target
   always_ff @(posedge clk) begin
      if (!reset) begin
         exc_valid      <= 1'b0;
         eret_commit    <= 1'b0;
         redirect_valid <= 1'b0;
         exc_code       <= 5'd0;
         exc_epc        <= 32'd0;
         exc_badvaddr   <= 32'd0;
         exc_bd         <= 1'b0;
         redirect_pc    <= 32'd0;
      end else begin
         exc_valid      <= hit;
         eret_commit    <= eret_take;
         redirect_valid <= hit | eret_take;
         if (hit) begin
            exc_code     <= code;
            exc_epc      <= epc_sel;
            exc_badvaddr <= bva_sel;
            exc_bd       <= bd_sel;
            redirect_pc  <= HANDLER_PC;
         end else if (eret_take) begin
            redirect_pc  <= epc_in;
         end
      end
   end

   // RUN/FLUSH sequencing; the counter holds the remaining flush cycles minus one
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_RUN;
         flush_cnt <= 3'd0;
      end else begin
         case (state)
            ST_RUN: begin
               if (hit || eret_take) begin
                  state     <= ST_FLUSH;
                  flush_cnt <= FLUSH_LOAD;
               end
            end
            default: begin
               if (flush_cnt == 3'd0) begin
                  state <= ST_RUN;
               end else begin
                  flush_cnt <= flush_cnt - 3'd1;
               end
            end
         endcase
      end
   end

   assign flush = (state == ST_FLUSH);

endmodule

// File: tb/tb_exc_arbiter.sv
// Testbench for exc_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the arbiter rules.
module tb_exc_arbiter;
   import cpu_pkg::*;

   localparam logic [31:0] HPC = 32'hBFC0_0380;
   localparam int          FC  = 2;

   logic        clk = 1'b0;
   logic        reset, ex_valid, if_adel, ri, ovf, syscall, brk, mem_err, mem_store;
   logic        is_branch_ex, eret, exl;
   logic [31:0] pc_if, pc_ex, mem_addr, epc_in;
   logic        exc_valid, exc_bd, eret_commit, redirect_valid, flush;
   logic [4:0]  exc_code;
   logic [31:0] exc_epc, exc_badvaddr, redirect_pc;
`ifdef EXC_INT_EN
   logic [5:0]  hw_int;
   logic [7:0]  int_mask;
`endif

   int errors = 0;
   int checks = 0;

   // Model state
   logic        m_bd;
   int          m_rem;
   logic        e_valid, e_eret, e_rv, e_flush, e_bd;
   logic [4:0]  e_code;
   logic [31:0] e_epc, e_bva, e_rpc;
`ifdef EXC_INT_EN
   logic [5:0]  m_s1, m_s2;
`endif

   always #5 clk = ~clk;

   exc_arbiter #(.HANDLER_PC(HPC), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .pc_if(pc_if), .pc_ex(pc_ex),
      .if_adel(if_adel), .ri(ri), .ovf(ovf), .syscall(syscall), .brk(brk),
      .mem_err(mem_err), .mem_store(mem_store), .mem_addr(mem_addr),
      .is_branch_ex(is_branch_ex), .eret(eret), .exl(exl), .epc_in(epc_in),
      .exc_valid(exc_valid), .exc_code(exc_code), .exc_epc(exc_epc),
      .exc_badvaddr(exc_badvaddr), .exc_bd(exc_bd), .eret_commit(eret_commit),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush)
`ifdef EXC_INT_EN
      , .hw_int(hw_int), .int_mask(int_mask)
`endif
   );

   task automatic clear_inputs();
      ex_valid = 0; if_adel = 0; ri = 0; ovf = 0; syscall = 0; brk = 0;
      mem_err = 0; mem_store = 0; is_branch_ex = 0; eret = 0; exl = 0;
      pc_if = 0; pc_ex = 0; mem_addr = 0; epc_in = 0;
`ifdef EXC_INT_EN
      hw_int = 0; int_mask = 0;
`endif
   endtask

   // Behavioural model: flush window counted in cycles, payload recomputed
   // from the priority list each cycle the arbiter is eligible.
   task automatic model_step();
      int   next_rem;
      logic take, int_pend;
      int_pend = 1'b0;
`ifdef EXC_INT_EN
      int_pend = ex_valid && ((m_s2 & int_mask[7:2]) != 0) && !exl;
`endif
      if (!reset) begin
         e_valid = 0; e_eret = 0; e_rv = 0; e_flush = 0; e_bd = 0;
         e_code = 0; e_epc = 0; e_bva = 0; e_rpc = 0;
         m_bd = 0; m_rem = 0;
`ifdef EXC_INT_EN
         m_s1 = 0; m_s2 = 0;
`endif
         return;
      end
      e_valid = 0; e_eret = 0; e_rv = 0;
      next_rem = (m_rem > 0) ? m_rem - 1 : 0;
      if (m_rem == 0) begin
         take = 1'b1;
         if (int_pend)                   e_code = 5'h00;
         else if (if_adel)               e_code = 5'h04;
         else if (ex_valid && ri)        e_code = 5'h0a;
         else if (ex_valid && ovf)       e_code = 5'h0c;
         else if (ex_valid && syscall)   e_code = 5'h08;
         else if (ex_valid && brk)       e_code = 5'h09;
         else if (mem_err)               e_code = mem_store ? 5'h05 : 5'h04;
         else                            take = 1'b0;
         if (take) begin
            if (!int_pend && if_adel) begin
               e_epc = pc_if; e_bva = pc_if; e_bd = 0;
            end else begin
               e_epc = m_bd ? pc_ex - 32'd4 : pc_ex;
               e_bd  = m_bd;
               e_bva = (e_code == 5'h05 || e_code == 5'h04) ? mem_addr : 32'd0;
            end
            e_valid = 1; e_rv = 1; e_rpc = HPC; next_rem = FC;
         end else if (ex_valid && eret) begin
            e_eret = 1; e_rv = 1; e_rpc = epc_in; next_rem = FC;
         end
      end
      m_rem   = next_rem;
      e_flush = (m_rem > 0);
      if (ex_valid) m_bd = is_branch_ex;
`ifdef EXC_INT_EN
      m_s2 = m_s1; m_s1 = hw_int;
`endif
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 0;
      cycle(); cycle();
      checks++;
      if ({exc_valid, eret_commit, redirect_valid, flush, exc_bd} !== 5'b0) begin
         errors++; $display("FAIL reset_strobes got=%b exp=00000", {exc_valid, eret_commit, redirect_valid, flush, exc_bd});
      end
      checks++;
      if ({exc_code, exc_epc, exc_badvaddr, redirect_pc} !== '0) begin
         errors++; $display("FAIL reset_payload code=%h epc=%h bva=%h rpc=%h exp all 0", exc_code, exc_epc, exc_badvaddr, redirect_pc);
      end
      reset = 1;
      cycle();
   endtask

   task automatic test_ovf();
      ex_valid = 1; ovf = 1; pc_ex = 32'h100;
      cycle();
      clear_inputs();
      checks++;
      if ({exc_valid, redirect_valid, eret_commit, flush} !== 4'b1101) begin
         errors++; $display("FAIL ovf_strobes got=%b exp=1101", {exc_valid, redirect_valid, eret_commit, flush});
      end
      checks++;
      if (exc_code !== 5'h0c || exc_epc !== 32'h100 || exc_bd !== 1'b0 || redirect_pc !== HPC) begin
         errors++; $display("FAIL ovf_payload code=%h epc=%h bd=%b rpc=%h exp 0c/100/0/bfc00380", exc_code, exc_epc, exc_bd, redirect_pc);
      end
      cycle();
      checks++;
      if (flush !== 1'b1 || exc_valid !== 1'b0) begin
         errors++; $display("FAIL ovf_flush2 flush=%b valid=%b exp 1/0", flush, exc_valid);
      end
      cycle();
      checks++;
      if (flush !== 1'b0) begin
         errors++; $display("FAIL ovf_flush_end flush=%b exp 0", flush);
      end
   endtask

   task automatic test_delay_slot();
      ex_valid = 1; is_branch_ex = 1; pc_ex = 32'h200;
      cycle();
      is_branch_ex = 0; syscall = 1; pc_ex = 32'h204;
      cycle();
      clear_inputs();
      checks++;
      if (exc_valid !== 1'b1 || exc_code !== 5'h08 || exc_epc !== 32'h200 || exc_bd !== 1'b1) begin
         errors++; $display("FAIL bd_syscall valid=%b code=%h epc=%h bd=%b exp 1/08/200/1", exc_valid, exc_code, exc_epc, exc_bd);
      end
      cycle(); cycle();
   endtask

   task automatic test_mem();
      mem_err = 1; mem_store = 1; mem_addr = 32'h1003;
      cycle();
      clear_inputs();
      checks++;
      if (exc_valid !== 1'b1 || exc_code !== 5'h05 || exc_badvaddr !== 32'h1003) begin
         errors++; $display("FAIL mem_store valid=%b code=%h bva=%h exp 1/05/1003", exc_valid, exc_code, exc_badvaddr);
      end
      cycle(); cycle();
      mem_err = 1; mem_store = 1; mem_addr = 32'h1003; ex_valid = 1; ri = 1; pc_ex = 32'h300;
      cycle();
      clear_inputs();
      checks++;
      if (exc_valid !== 1'b1 || exc_code !== 5'h0a || exc_badvaddr !== 32'h0) begin
         errors++; $display("FAIL mem_vs_ri valid=%b code=%h bva=%h exp 1/0a/0", exc_valid, exc_code, exc_badvaddr);
      end
      cycle(); cycle();
   endtask

   task automatic test_eret();
      ex_valid = 1; eret = 1; epc_in = 32'h400;
      cycle();
      clear_inputs();
      checks++;
      if ({eret_commit, redirect_valid, exc_valid, flush} !== 4'b1101 || redirect_pc !== 32'h400) begin
         errors++; $display("FAIL eret got=%b rpc=%h exp 1101/400", {eret_commit, redirect_valid, exc_valid, flush}, redirect_pc);
      end
      cycle(); cycle();
      ex_valid = 1; eret = 1; brk = 1; epc_in = 32'h400; pc_ex = 32'h500;
      cycle();
      clear_inputs();
      checks++;
      if (exc_valid !== 1'b1 || exc_code !== 5'h09 || eret_commit !== 1'b0 || redirect_pc !== HPC) begin
         errors++; $display("FAIL eret_vs_brk valid=%b code=%h eret=%b rpc=%h exp 1/09/0/bfc00380", exc_valid, exc_code, eret_commit, redirect_pc);
      end
      cycle(); cycle();
   endtask

   task automatic test_flush_window();
      ex_valid = 1; ovf = 1; pc_ex = 32'h600;
      cycle();
      ovf = 0; brk = 1; pc_ex = 32'h604;
      cycle();
      checks++;
      if (exc_valid !== 1'b0 || redirect_valid !== 1'b0) begin
         errors++; $display("FAIL brk_in_flush1 valid=%b rv=%b exp 0/0", exc_valid, redirect_valid);
      end
      cycle();
      checks++;
      if (exc_valid !== 1'b0 || flush !== 1'b0) begin
         errors++; $display("FAIL brk_in_flush2 valid=%b flush=%b exp 0/0", exc_valid, flush);
      end
      pc_ex = 32'h608;
      cycle();
      clear_inputs();
      checks++;
      if (exc_valid !== 1'b1 || exc_code !== 5'h09 || exc_epc !== 32'h608) begin
         errors++; $display("FAIL brk_after_flush valid=%b code=%h epc=%h exp 1/09/608", exc_valid, exc_code, exc_epc);
      end
      reset = 0;
      cycle();
      reset = 1;
      checks++;
      if ({flush, exc_valid, redirect_valid, eret_commit} !== 4'b0 || redirect_pc !== 32'h0) begin
         errors++; $display("FAIL reset_mid_flush got=%b rpc=%h exp 0000/0", {flush, exc_valid, redirect_valid, eret_commit}, redirect_pc);
      end
      ex_valid = 1; brk = 1; pc_ex = 32'h700;
      cycle();
      clear_inputs();
      checks++;
      if (exc_valid !== 1'b1 || exc_code !== 5'h09) begin
         errors++; $display("FAIL run_after_reset valid=%b code=%h exp 1/09", exc_valid, exc_code);
      end
      cycle(); cycle();
   endtask

`ifdef EXC_INT_EN
   task automatic test_interrupt();
      hw_int = 6'h01; int_mask = 8'h04; exl = 0; ex_valid = 1; pc_ex = 32'h800;
      cycle(); cycle();
      checks++;
      if (exc_valid !== 1'b0) begin
         errors++; $display("FAIL int_early valid=%b exp 0", exc_valid);
      end
      cycle();
      hw_int = 0;
      checks++;
      if (exc_valid !== 1'b1 || exc_code !== 5'h00) begin
         errors++; $display("FAIL int_take valid=%b code=%h exp 1/00", exc_valid, exc_code);
      end
      clear_inputs();
      cycle(); cycle(); cycle();
      hw_int = 6'h01; int_mask = 8'h04; exl = 1; ex_valid = 1;
      cycle(); cycle(); cycle(); cycle();
      checks++;
      if (exc_valid !== 1'b0) begin
         errors++; $display("FAIL int_exl valid=%b exp 0", exc_valid);
      end
      clear_inputs();
      cycle(); cycle();
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         reset        = ($urandom_range(0, 49) != 0);
         ex_valid     = ($urandom_range(0, 3) != 0);
         is_branch_ex = ($urandom_range(0, 3) == 0);
         if_adel      = ($urandom_range(0, 15) == 0);
         ri           = ($urandom_range(0, 11) == 0);
         ovf          = ($urandom_range(0, 11) == 0);
         syscall      = ($urandom_range(0, 11) == 0);
         brk          = ($urandom_range(0, 11) == 0);
         mem_err      = ($urandom_range(0, 11) == 0);
         mem_store    = $urandom_range(0, 1);
         eret         = ($urandom_range(0, 7) == 0);
         exl          = $urandom_range(0, 1);
         pc_if        = $urandom;
         pc_ex        = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
         mem_addr     = $urandom;
         epc_in       = $urandom;
`ifdef EXC_INT_EN
         hw_int       = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
         int_mask     = 8'($urandom);
`endif
         cycle();
         checks++;
         if ({exc_valid, eret_commit, redirect_valid, flush} !== {e_valid, e_eret, e_rv, e_flush}) begin
            errors++; $display("FAIL rnd_ctrl i=%0d got=%b exp=%b", i, {exc_valid, eret_commit, redirect_valid, flush}, {e_valid, e_eret, e_rv, e_flush});
         end
         if (e_valid) begin
            checks++;
            if (exc_code !== e_code || exc_epc !== e_epc || exc_badvaddr !== e_bva || exc_bd !== e_bd) begin
               errors++; $display("FAIL rnd_payload i=%0d got=%h/%h/%h/%b exp=%h/%h/%h/%b", i, exc_code, exc_epc, exc_badvaddr, exc_bd, e_code, e_epc, e_bva, e_bd);
            end
         end
         if (e_rv) begin
            checks++;
            if (redirect_pc !== e_rpc) begin
               errors++; $display("FAIL rnd_rpc i=%0d got=%h exp=%h", i, redirect_pc, e_rpc);
            end
         end
      end
      reset = 1;
      clear_inputs();
      cycle(); cycle(); cycle();
   endtask

   initial begin
      clear_inputs();
      reset = 0;
      m_bd = 0; m_rem = 0;
      test_reset();
      test_ovf();
      test_delay_slot();
      test_mem();
      test_eret();
      test_flush_window();
`ifdef EXC_INT_EN
      test_interrupt();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
